panel_status_monitor: RTL and testbench

Parametrised status/health monitor for Barco NX4 panel drivers; successor to the single-panel blank counter and XERR pass-through in the top level. Counts frames on led_blank rising edges, runs a frame watchdog, and filters and latches XERR per panel for N_PANELS chained drivers. Drives the three status LEDs and the CPLD watchdog kick. Sits beside the image driver in the top level and observes only its blank output.

---
 rtl/nx4_status_pkg.sv | 36 +++
 rtl/xerr_filter.sv | 48 ++++
 rtl/panel_status_monitor.sv | 123 ++++++++++++
 tb/tb_panel_status_monitor.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx4_status_pkg.sv
// Shared defaults and LED drive encoding for the NX4 panel status monitor.
package nx4_status_pkg;

    localparam int DEFAULT_WDOG_CYCLES = 1000000;
    localparam int DEFAULT_XERR_FILT   = 16;
    localparam int DEFAULT_BLINK_W     = 22;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_SOLID = 2'd1,
        LED_BLINK = 2'd2
    } led_mode_t;

    // A live fault outranks a fault that has only been seen since the last clear.
    function automatic led_mode_t red_mode(input logic any_live, input logic any_sticky);
        led_mode_t mode;
        mode = LED_OFF;
        if (any_live) begin
            mode = LED_SOLID;
        end else if (any_sticky) begin
            mode = LED_BLINK;
        end
        return mode;
    endfunction

    function automatic logic led_drive(input led_mode_t mode, input logic blink_phase);
        logic level;
        case (mode)
            LED_SOLID: level = 1'b1;
            LED_BLINK: level = blink_phase;
            default:   level = 1'b0;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/xerr_filter.sv
// One panel's XERR glitch filter: a run of low samples sets the live flag,
// any high sample releases it at once; the sticky bit remembers live faults.
module xerr_filter
    import nx4_status_pkg::*;
#(
    parameter int XERR_FILT = DEFAULT_XERR_FILT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic xerr_n,
    input  logic err_clear,
    output logic live,
    output logic sticky,
    output logic rise
);

    localparam int CNT_W = $clog2(XERR_FILT + 1);
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(XERR_FILT);

    logic [CNT_W-1:0] filt;
    logic             at_threshold;

    // True when this low sample is the one that reaches (or holds) the threshold.
    assign at_threshold = (filt >= FILT_MAX - 1'b1);
    assign rise         = ~xerr_n & at_threshold & ~live;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            filt   <= '0;
            live   <= 1'b0;
            sticky <= 1'b0;
        end else begin
            if (xerr_n) begin
                filt <= '0;
                live <= 1'b0;
            end else begin
                if (filt != FILT_MAX) begin
                    filt <= filt + 1'b1;
                end
                if (at_threshold) begin
                    live <= 1'b1;
                end
            end
            sticky <= live | (sticky & ~err_clear);
        end
    end

endmodule

// File: rtl/panel_status_monitor.sv
// Panel driver health monitor: frame counting on blank rising edges, frame
// watchdog, per-panel XERR filtering, error event counting and status LEDs.
module panel_status_monitor
    import nx4_status_pkg::*;
#(
    parameter int N_PANELS    = 1,
    parameter int FRAME_W     = 10,
    parameter int WDOG_CYCLES = DEFAULT_WDOG_CYCLES,
    parameter int XERR_FILT   = DEFAULT_XERR_FILT,
    parameter int ERRCNT_W    = 8,
    parameter int BLINK_W     = DEFAULT_BLINK_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                led_blank,
    input  logic [N_PANELS-1:0] led_xerr,
    input  logic                err_clear,
    output logic                status_yellow,
    output logic                status_orange,
    output logic                status_red,
    output logic                cpld_p8,
    output logic [FRAME_W-1:0]  frame_count,
    output logic                stall,
    output logic [N_PANELS-1:0] xerr_live,
    output logic [N_PANELS-1:0] xerr_sticky,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0]   WDOG_MAX = WDOG_W'(WDOG_CYCLES);
    localparam logic [ERRCNT_W-1:0] ERR_MAX  = '1;

    logic                blank_prev;
    logic                edge_armed;
    logic                blank_rise;
    logic [WDOG_W-1:0]   wdog_cnt;
    logic [BLINK_W-1:0]  blink_div;
    logic [N_PANELS-1:0] xerr_rise;
    logic                any_rise;
    led_mode_t           red_sel;

    // edge_armed suppresses a false edge when blank is already high as reset releases.
    assign blank_rise = led_blank & ~blank_prev & edge_armed;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blank_prev <= 1'b0;
            edge_armed <= 1'b0;
            cpld_p8    <= 1'b0;
        end else begin
            blank_prev <= led_blank;
            edge_armed <= 1'b1;
            cpld_p8    <= led_blank;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (blank_rise) begin
            frame_count <= frame_count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wdog_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            if (blank_rise) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != WDOG_MAX) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (err_clear) begin
                stall <= 1'b0;
            end else if ((wdog_cnt == WDOG_MAX - 1'b1) && !blank_rise) begin
                stall <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_PANELS; i++) begin : g_panel
        xerr_filter #(
            .XERR_FILT(XERR_FILT)
        ) u_filter (
            .clock    (clock),
            .reset_n  (reset_n),
            .xerr_n   (led_xerr[i]),
            .err_clear(err_clear),
            .live     (xerr_live[i]),
            .sticky   (xerr_sticky[i]),
            .rise     (xerr_rise[i])
        );
    end

    assign any_rise = |xerr_rise;

    // Panels faulting together are one event; a clear coinciding with an event leaves 1.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= any_rise ? ERRCNT_W'(1) : '0;
        end else if (any_rise && (err_count != ERR_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blink_div <= '0;
        end else begin
            blink_div <= blink_div + 1'b1;
        end
    end

    assign red_sel       = red_mode(|xerr_live, |xerr_sticky);
    assign status_red    = led_drive(red_sel, blink_div[BLINK_W-1]);
    assign status_yellow = frame_count[FRAME_W-1];
    assign status_orange = stall;

endmodule

// File: tb/tb_panel_status_monitor.sv
// Directed bench for panel_status_monitor with small parameters so that
// frame wrap, watchdog expiry, filter threshold and counter saturation are reachable.
module tb_panel_status_monitor;

    localparam int N_PANELS    = 2;
    localparam int FRAME_W     = 4;
    localparam int WDOG_CYCLES = 100;
    localparam int XERR_FILT   = 4;
    localparam int ERRCNT_W    = 2;
    localparam int BLINK_W     = 4;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                led_blank;
    logic [N_PANELS-1:0] led_xerr;
    logic                err_clear;
    logic                status_yellow;
    logic                status_orange;
    logic                status_red;
    logic                cpld_p8;
    logic [FRAME_W-1:0]  frame_count;
    logic                stall;
    logic [N_PANELS-1:0] xerr_live;
    logic [N_PANELS-1:0] xerr_sticky;
    logic [ERRCNT_W-1:0] err_count;

    logic [BLINK_W-1:0]  blink_ref;
    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    // Reference blink phase: free-running count of clock edges since reset.
    always @(posedge clock) begin
        if (!reset_n) blink_ref <= '0;
        else          blink_ref <= blink_ref + 1'b1;
    end

    panel_status_monitor #(
        .N_PANELS   (N_PANELS),
        .FRAME_W    (FRAME_W),
        .WDOG_CYCLES(WDOG_CYCLES),
        .XERR_FILT  (XERR_FILT),
        .ERRCNT_W   (ERRCNT_W),
        .BLINK_W    (BLINK_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .led_blank    (led_blank),
        .led_xerr     (led_xerr),
        .err_clear    (err_clear),
        .status_yellow(status_yellow),
        .status_orange(status_orange),
        .status_red   (status_red),
        .cpld_p8      (cpld_p8),
        .frame_count  (frame_count),
        .stall        (stall),
        .xerr_live    (xerr_live),
        .xerr_sticky  (xerr_sticky),
        .err_count    (err_count)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        led_blank = 1'b0;
        led_xerr  = '1;
        err_clear = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        led_blank = 1'b1;
        led_xerr  = 2'b00;
        err_clear = 1'b0;
        repeat (6) tick();
        n_compared++;
        if ({status_yellow, status_orange, status_red, stall, frame_count} !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_status: got %b want 00000000", {status_yellow, status_orange, status_red, stall, frame_count});
        end
        n_compared++;
        if ({xerr_live, xerr_sticky, err_count, cpld_p8} !== 7'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_xerr_cpld: got %b want 0000000", {xerr_live, xerr_sticky, err_count, cpld_p8});
        end
        led_xerr = 2'b11;
        reset_n  = 1'b1;
        tick();
        n_compared++;
        if (cpld_p8 !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL cpld_follow_high: got %b want 1", cpld_p8);
        end
        n_compared++;
        if (frame_count !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL no_edge_at_release: got %0d want 0", frame_count);
        end
        tick();
        led_blank = 1'b0;
        tick();
        n_compared++;
        if ({cpld_p8, frame_count} !== 5'b0_0000) begin
            n_mismatched++;
            $display("[TB] FAIL after_blank_drop: got cpld=%b frame=%0d want cpld=0 frame=0", cpld_p8, frame_count);
        end
        led_blank = 1'b1;
        tick();
        n_compared++;
        if ({cpld_p8, frame_count} !== 5'b1_0001) begin
            n_mismatched++;
            $display("[TB] FAIL second_rise: got cpld=%b frame=%0d want cpld=1 frame=1", cpld_p8, frame_count);
        end
        led_blank = 1'b0;
        tick();
    endtask

    task automatic test_frame_wrap();
        apply_reset();
        for (int p = 1; p <= 17; p++) begin
            led_blank = 1'b1;
            tick();
            led_blank = 1'b0;
            tick();
            if (p == 7) begin
                n_compared++;
                if ({status_yellow, frame_count} !== 5'b0_0111) begin
                    n_mismatched++;
                    $display("[TB] FAIL frame7: got y=%b frame=%0d want y=0 frame=7", status_yellow, frame_count);
                end
            end
            if (p == 8) begin
                n_compared++;
                if ({status_yellow, frame_count} !== 5'b1_1000) begin
                    n_mismatched++;
                    $display("[TB] FAIL frame8_yellow: got y=%b frame=%0d want y=1 frame=8", status_yellow, frame_count);
                end
            end
            if (p == 16) begin
                n_compared++;
                if ({status_yellow, frame_count} !== 5'b0_0000) begin
                    n_mismatched++;
                    $display("[TB] FAIL frame_wrap0: got y=%b frame=%0d want y=0 frame=0", status_yellow, frame_count);
                end
            end
        end
        n_compared++;
        if (frame_count !== 4'd1) begin
            n_mismatched++;
            $display("[TB] FAIL frame_after17: got %0d want 1", frame_count);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        led_blank = 1'b1;
        tick();
        led_blank = 1'b0;
        repeat (99) tick();
        n_compared++;
        if (stall !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL wdog_99_idle: got %b want 0", stall);
        end
        tick();
        n_compared++;
        if ({stall, status_orange} !== 2'b11) begin
            n_mismatched++;
            $display("[TB] FAIL wdog_100_stall: got stall/orange=%b want 11", {stall, status_orange});
        end
        led_blank = 1'b1;
        tick();
        led_blank = 1'b0;
        tick();
        n_compared++;
        if (stall !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL stall_sticky_after_pulse: got %b want 1", stall);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_compared++;
        if ({stall, status_orange} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL stall_cleared: got %b want 00", {stall, status_orange});
        end
    endtask

    task automatic test_watchdog_clear_race();
        apply_reset();
        led_blank = 1'b1;
        tick();
        led_blank = 1'b0;
        repeat (99) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_compared++;
        if (stall !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL clear_wins_stall: got %b want 0", stall);
        end
        led_blank = 1'b1;
        tick();
        led_blank = 1'b0;
        repeat (99) tick();
        n_compared++;
        if (stall !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rearm_99: got %b want 0", stall);
        end
        tick();
        n_compared++;
        if (stall !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rearm_100: got %b want 1", stall);
        end
    endtask

    task automatic test_filter();
        apply_reset();
        led_xerr = 2'b10;
        repeat (3) tick();
        led_xerr = 2'b11;
        tick();
        n_compared++;
        if ({xerr_live, xerr_sticky, err_count} !== 6'b00_00_00) begin
            n_mismatched++;
            $display("[TB] FAIL glitch3_ignored: got live/sticky/cnt=%b want 000000", {xerr_live, xerr_sticky, err_count});
        end
        led_xerr = 2'b10;
        repeat (3) tick();
        n_compared++;
        if (xerr_live !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL low3_not_live: got %b want 00", xerr_live);
        end
        tick();
        n_compared++;
        if ({xerr_live, err_count, status_red, xerr_sticky} !== 7'b01_01_1_00) begin
            n_mismatched++;
            $display("[TB] FAIL low4_live: got live/cnt/red/sticky=%b want 0101100", {xerr_live, err_count, status_red, xerr_sticky});
        end
        tick();
        n_compared++;
        if ({xerr_sticky, err_count} !== 4'b01_01) begin
            n_mismatched++;
            $display("[TB] FAIL held_sticky: got sticky/cnt=%b want 0101", {xerr_sticky, err_count});
        end
        led_xerr = 2'b11;
        tick();
        n_compared++;
        if ({xerr_live, xerr_sticky} !== 4'b00_01) begin
            n_mismatched++;
            $display("[TB] FAIL release_immediate: got live/sticky=%b want 0001", {xerr_live, xerr_sticky});
        end
        for (int k = 0; k < 16; k++) begin
            n_compared++;
            if (status_red !== blink_ref[BLINK_W-1]) begin
                n_mismatched++;
                $display("[TB] FAIL red_blink k=%0d: got %b want %b", k, status_red, blink_ref[BLINK_W-1]);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        led_xerr = 2'b00;
        repeat (4) tick();
        n_compared++;
        if ({xerr_live, err_count} !== 4'b11_01) begin
            n_mismatched++;
            $display("[TB] FAIL both_rise_one_event: got live/cnt=%b want 1101", {xerr_live, err_count});
        end
        tick();
        led_xerr = 2'b01;
        tick();
        n_compared++;
        if ({xerr_live, xerr_sticky, status_red} !== 5'b10_11_1) begin
            n_mismatched++;
            $display("[TB] FAIL panel0_released: got live/sticky/red=%b want 10111", {xerr_live, xerr_sticky, status_red});
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_compared++;
        if ({xerr_sticky, err_count} !== 4'b10_00) begin
            n_mismatched++;
            $display("[TB] FAIL clear_live_wins: got sticky/cnt=%b want 1000", {xerr_sticky, err_count});
        end
        led_xerr = 2'b11;
        tick();
        led_xerr = 2'b10;
        repeat (4) tick();
        led_xerr = 2'b11;
        tick();
        n_compared++;
        if (err_count !== 2'd1) begin
            n_mismatched++;
            $display("[TB] FAIL count_after_event: got %0d want 1", err_count);
        end
        led_xerr = 2'b10;
        repeat (3) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_compared++;
        if ({err_count, xerr_live, xerr_sticky} !== 6'b01_01_00) begin
            n_mismatched++;
            $display("[TB] FAIL clear_with_rise: got cnt/live/sticky=%b want 010100", {err_count, xerr_live, xerr_sticky});
        end
        tick();
        led_xerr = 2'b11;
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int e = 1; e <= 5; e++) begin
            led_xerr = 2'b10;
            repeat (4) tick();
            led_xerr = 2'b11;
            tick();
            if (e == 2) begin
                n_compared++;
                if (err_count !== 2'd2) begin
                    n_mismatched++;
                    $display("[TB] FAIL count_event2: got %0d want 2", err_count);
                end
            end
        end
        n_compared++;
        if (err_count !== 2'd3) begin
            n_mismatched++;
            $display("[TB] FAIL count_saturated: got %0d want 3", err_count);
        end
        led_xerr = 2'b10;
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        n_compared++;
        if ({err_count, xerr_live, xerr_sticky, stall, frame_count} !== 11'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_fault: got %b want 00000000000", {err_count, xerr_live, xerr_sticky, stall, frame_count});
        end
        reset_n = 1'b1;
        repeat (3) tick();
        n_compared++;
        if (xerr_live !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL filter_restart_3: got %b want 00", xerr_live);
        end
        tick();
        n_compared++;
        if ({xerr_live, err_count} !== 4'b01_01) begin
            n_mismatched++;
            $display("[TB] FAIL filter_restart_4: got live/cnt=%b want 0101", {xerr_live, err_count});
        end
        led_xerr = 2'b11;
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        led_blank = 1'b0;
        led_xerr  = '1;
        err_clear = 1'b0;
        test_reset();
        test_frame_wrap();
        test_watchdog();
        test_watchdog_clear_race();
        test_filter();
        test_simultaneous();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
